// File: rtl/draw_symbol_gen_if.sv
// Request/pixel bundle between the game-level controller and draw_symbol_gen.
// The erase signal exists only when DRAW_SYMBOL_GEN_ERASE_EN is defined.
interface draw_symbol_gen_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
);
  logic           start;
  logic [1:0]     mode;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour_in;
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
  logic           erase;
`endif
  logic [X_W-1:0] xout;
  logic [Y_W-1:0] yout;
  logic [2:0]     colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
    output erase,
`endif
    output start, mode, x, y, colour_in,
    input  xout, yout, colour, plot, busy, done
  );

  modport slave (
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
    input  erase,
`endif
    input  start, mode, x, y, colour_in,
    output xout, yout, colour, plot, busy, done
  );
endinterface

// File: rtl/draw_symbol_gen.sv
// Symbol plotter: emits cross / outline / plus / filled square pixels, one per clock.
// Optional feature macro: DRAW_SYMBOL_GEN_ERASE_EN (adds erase input forcing colour 0).
module draw_symbol_gen #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned X_W  = 8,
  parameter int unsigned Y_W  = 7
) (
  input logic         clk,
  input logic         reset,
  draw_symbol_gen_if.slave bus
);

  localparam int unsigned CW = $clog2(SIZE + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LastIdx = cnt_t'(SIZE - 1);
  localparam cnt_t EdgeIdx = cnt_t'(SIZE - 2);
  localparam cnt_t Half    = cnt_t'(SIZE / 2);

  localparam logic [1:0] ModeCross   = 2'd0;
  localparam logic [1:0] ModeOutline = 2'd1;
  localparam logic [1:0] ModePlus    = 2'd2;
  localparam logic [1:0] ModeFill    = 2'd3;

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [X_W-1:0] org_x_q, org_x_d;
  logic [Y_W-1:0] org_y_q, org_y_d;
  logic [2:0]     col_q, col_d;
  logic [1:0]     seg_q, seg_d;
  cnt_t           k_q, k_d;
  cnt_t           r_q, r_d;
  logic           last_q, last_d;
  logic [X_W-1:0] xout_q, xout_d;
  logic [Y_W-1:0] yout_q, yout_d;
  logic [2:0]     colour_q, colour_d;
  logic           plot_q, plot_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
  logic           erase_q, erase_d;
`endif

  cnt_t       dx, dy, k_end;
  logic       row_end, pix_last;
  logic [2:0] pix_colour;

  // Offset of the pixel selected by the current (seg, k, r) counters.
  always_comb begin
    dx = '0;
    dy = '0;
    unique case (mode_q)
      ModeCross: begin
        dx = seg_q[0] ? LastIdx - k_q : k_q;
        dy = k_q;
      end
      ModeOutline: begin
        case (seg_q)
          2'd0:    begin dx = k_q;           dy = '0;            end
          2'd1:    begin dx = LastIdx;       dy = k_q;           end
          2'd2:    begin dx = LastIdx - k_q; dy = LastIdx;       end
          default: begin dx = '0;            dy = LastIdx - k_q; end
        endcase
      end
      ModePlus: begin
        dx = seg_q[0] ? Half : k_q;
        dy = seg_q[0] ? k_q : Half;
      end
      ModeFill: begin
        dx = k_q;
        dy = r_q;
      end
    endcase

    k_end    = (mode_q == ModeOutline) ? EdgeIdx : LastIdx;
    row_end  = (mode_q == ModeFill)    ? (r_q == LastIdx)
             : (mode_q == ModeOutline) ? (seg_q == 2'd3)
             :                           (seg_q == 2'd1);
    pix_last = (k_q == k_end) && row_end;

`ifdef DRAW_SYMBOL_GEN_ERASE_EN
    pix_colour = erase_q ? 3'b000 : col_q;
`else
    pix_colour = col_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    org_x_d  = org_x_q;
    org_y_d  = org_y_q;
    col_d    = col_q;
    seg_d    = seg_q;
    k_d      = k_q;
    r_d      = r_q;
    last_d   = last_q;
    xout_d   = xout_q;
    yout_d   = yout_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
    erase_d  = erase_q;
`endif

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = StDraw;
          busy_d  = 1'b1;
          mode_d  = bus.mode;
          org_x_d = bus.x;
          org_y_d = bus.y;
          col_d   = bus.colour_in;
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
          erase_d = bus.erase;
`endif
          seg_d   = '0;
          k_d     = '0;
          r_d     = '0;
          last_d  = 1'b0;
        end
      end
      StDraw: begin
        // last_q marks that the final pixel already went out on the previous edge.
        if (last_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          last_d  = 1'b0;
        end else begin
          plot_d   = 1'b1;
          xout_d   = org_x_q + X_W'(dx);
          yout_d   = org_y_q + Y_W'(dy);
          colour_d = pix_colour;
          last_d   = pix_last;
          if (k_q == k_end) begin
            k_d = '0;
            if (mode_q == ModeFill) r_d = r_q + cnt_t'(1);
            else                    seg_d = seg_q + 2'd1;
          end else begin
            k_d = k_q + cnt_t'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      org_x_q  <= '0;
      org_y_q  <= '0;
      col_q    <= '0;
      seg_q    <= '0;
      k_q      <= '0;
      r_q      <= '0;
      last_q   <= 1'b0;
      xout_q   <= '0;
      yout_q   <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
      erase_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      col_q    <= col_d;
      seg_q    <= seg_d;
      k_q      <= k_d;
      r_q      <= r_d;
      last_q   <= last_d;
      xout_q   <= xout_d;
      yout_q   <= yout_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
      erase_q  <= erase_d;
`endif
    end
  end

  assign bus.xout   = xout_q;
  assign bus.yout   = yout_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_draw_symbol_gen.sv
// Directed bench for draw_symbol_gen: three instances (SIZE 16, 4, 8) checked against
// hand-computed pixel sequences, including wrap-around, restart and mid-draw reset.
module tb_draw_symbol_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance drive/observe arrays: index 0 = SIZE16, 1 = SIZE4, 2 = SIZE8.
  logic       st[3];
  logic [1:0] md[3];
  logic [7:0] xi[3];
  logic [6:0] yi[3];
  logic [2:0] ci[3];
  logic       er[3];
  logic       rs[3];
  logic [7:0] xo[3];
  logic [6:0] yo[3];
  logic [2:0] co[3];
  logic       pl[3], bz[3], dn[3];

  draw_symbol_gen_if #(.X_W(8), .Y_W(7)) ifc16 ();
  draw_symbol_gen_if #(.X_W(8), .Y_W(7)) ifc4 ();
  draw_symbol_gen_if #(.X_W(8), .Y_W(7)) ifc8 ();

  assign ifc16.start = st[0]; assign ifc16.mode = md[0]; assign ifc16.x = xi[0];
  assign ifc16.y = yi[0];     assign ifc16.colour_in = ci[0];
  assign ifc4.start = st[1];  assign ifc4.mode = md[1];  assign ifc4.x = xi[1];
  assign ifc4.y = yi[1];      assign ifc4.colour_in = ci[1];
  assign ifc8.start = st[2];  assign ifc8.mode = md[2];  assign ifc8.x = xi[2];
  assign ifc8.y = yi[2];      assign ifc8.colour_in = ci[2];
`ifdef DRAW_SYMBOL_GEN_ERASE_EN
  assign ifc16.erase = er[0]; assign ifc4.erase = er[1]; assign ifc8.erase = er[2];
`endif

  assign xo[0] = ifc16.xout; assign yo[0] = ifc16.yout; assign co[0] = ifc16.colour;
  assign pl[0] = ifc16.plot; assign bz[0] = ifc16.busy; assign dn[0] = ifc16.done;
  assign xo[1] = ifc4.xout;  assign yo[1] = ifc4.yout;  assign co[1] = ifc4.colour;
  assign pl[1] = ifc4.plot;  assign bz[1] = ifc4.busy;  assign dn[1] = ifc4.done;
  assign xo[2] = ifc8.xout;  assign yo[2] = ifc8.yout;  assign co[2] = ifc8.colour;
  assign pl[2] = ifc8.plot;  assign bz[2] = ifc8.busy;  assign dn[2] = ifc8.done;

  draw_symbol_gen #(.SIZE(16), .X_W(8), .Y_W(7)) u_dut16 (.clk(clk), .reset(rs[0]), .bus(ifc16));
  draw_symbol_gen #(.SIZE(4),  .X_W(8), .Y_W(7)) u_dut4  (.clk(clk), .reset(rs[1]), .bus(ifc4));
  draw_symbol_gen #(.SIZE(8),  .X_W(8), .Y_W(7)) u_dut8  (.clk(clk), .reset(rs[2]), .bus(ifc8));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive a start pulse now (at a falling edge); check the accept cycle one clock later.
  task automatic start_draw(input int d, input int m, input int xx, input int yy, input int c,
                            input int e);
    st[d] = 1'b1; md[d] = 2'(m); xi[d] = 8'(xx); yi[d] = 7'(yy); ci[d] = 3'(c); er[d] = 1'(e);
    @(negedge clk);
    st[d] = 1'b0;
    check_eq($sformatf("accept_busy[%0d]", d), int'(bz[d]), 1);
    check_eq($sformatf("accept_plot[%0d]", d), int'(pl[d]), 0);
  endtask

  task automatic expect_pix(input int d, input string tag, input int i, input int ex,
                            input int ey, input int ec);
    @(negedge clk);
    check_eq($sformatf("%s_plot[%0d]", tag, i), int'(pl[d]), 1);
    check_eq($sformatf("%s_x[%0d]", tag, i), int'(xo[d]), ex);
    check_eq($sformatf("%s_y[%0d]", tag, i), int'(yo[d]), ey);
    check_eq($sformatf("%s_col[%0d]", tag, i), int'(co[d]), ec);
    check_eq($sformatf("%s_done[%0d]", tag, i), int'(dn[d]), 0);
  endtask

  task automatic expect_end(input int d, input string tag);
    @(negedge clk);
    check_eq({tag, "_done"}, int'(dn[d]), 1);
    check_eq({tag, "_done_plot"}, int'(pl[d]), 0);
    check_eq({tag, "_done_busy"}, int'(bz[d]), 1);
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, int'(bz[d]), 0);
    check_eq({tag, "_idle_done"}, int'(dn[d]), 0);
  endtask

  int ol_x[12] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0};
  int ol_y[12] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 2, 1};
  int cr_x[8]  = '{50, 51, 52, 53, 53, 52, 51, 50};
  int cr_y[8]  = '{10, 11, 12, 13, 10, 11, 12, 13};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; md[d] = '0; xi[d] = '0; yi[d] = '0; ci[d] = '0; er[d] = 1'b0; rs[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_x[%0d]", d), int'(xo[d]), 0);
      check_eq($sformatf("rst_y[%0d]", d), int'(yo[d]), 0);
      check_eq($sformatf("rst_col[%0d]", d), int'(co[d]), 0);
      check_eq($sformatf("rst_plot[%0d]", d), int'(pl[d]), 0);
      check_eq($sformatf("rst_busy[%0d]", d), int'(bz[d]), 0);
      check_eq($sformatf("rst_done[%0d]", d), int'(dn[d]), 0);
      rs[d] = 1'b0;
    end

    // Cross, SIZE 16 at (10,20): main diagonal then anti-diagonal.
    start_draw(0, 0, 10, 20, 5, 0);
    for (int i = 0; i < 16; i++) expect_pix(0, "cross", i, 10 + i, 20 + i, 5);
    for (int i = 0; i < 16; i++) expect_pix(0, "cross", 16 + i, 25 - i, 20 + i, 5);
    expect_end(0, "cross");

    // Outline, SIZE 4 at origin, clockwise with no repeated corners.
    start_draw(1, 1, 0, 0, 2, 0);
    for (int i = 0; i < 12; i++) expect_pix(1, "outl", i, ol_x[i], ol_y[i], 2);
    expect_end(1, "outl");

    // Filled, SIZE 8 at (250,126): both coordinates wrap.
    start_draw(2, 3, 250, 126, 6, 0);
    for (int i = 0; i < 64; i++)
      expect_pix(2, "fill", i, (250 + i % 8) % 256, (126 + i / 8) % 128, 6);
    expect_end(2, "fill");

    // Mid-draw start and changed inputs are ignored; start held through DONE restarts.
    start_draw(1, 1, 0, 0, 4, 0);
    for (int i = 0; i < 12; i++) begin
      expect_pix(1, "ign", i, ol_x[i], ol_y[i], 4);
      if (i == 3) begin
        st[1] = 1'b1; md[1] = 2'd0; xi[1] = 8'd50; yi[1] = 7'd10; ci[1] = 3'd1;
      end else if (i == 4) begin
        st[1] = 1'b0;
      end else if (i == 11) begin
        st[1] = 1'b1;
      end
    end
    @(negedge clk);
    check_eq("b2b_done", int'(dn[1]), 1);
    check_eq("b2b_done_busy", int'(bz[1]), 1);
    @(negedge clk);
    check_eq("b2b_gap_busy", int'(bz[1]), 0);
    check_eq("b2b_gap_plot", int'(pl[1]), 0);
    @(negedge clk);
    check_eq("b2b_accept_busy", int'(bz[1]), 1);
    check_eq("b2b_accept_plot", int'(pl[1]), 0);
    st[1] = 1'b0;
    for (int i = 0; i < 8; i++) expect_pix(1, "b2b", i, cr_x[i], cr_y[i], 1);
    expect_end(1, "b2b");

    // Plus, SIZE 16 at (100,40), reset after the sixth pixel.
    start_draw(0, 2, 100, 40, 3, 0);
    for (int i = 0; i < 6; i++) expect_pix(0, "plus_a", i, 100 + i, 48, 3);
    rs[0] = 1'b1;
    @(negedge clk);
    rs[0] = 1'b0;
    check_eq("mrst_plot", int'(pl[0]), 0);
    check_eq("mrst_busy", int'(bz[0]), 0);
    check_eq("mrst_done", int'(dn[0]), 0);
    check_eq("mrst_x", int'(xo[0]), 0);
    check_eq("mrst_y", int'(yo[0]), 0);
    check_eq("mrst_col", int'(co[0]), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("mrst_nodone[%0d]", i), int'(dn[0]), 0);
      check_eq($sformatf("mrst_noplot[%0d]", i), int'(pl[0]), 0);
    end
    start_draw(0, 2, 100, 40, 3, 0);
    for (int i = 0; i < 16; i++) expect_pix(0, "plus", i, 100 + i, 48, 3);
    for (int i = 0; i < 16; i++) expect_pix(0, "plus", 16 + i, 108, 40 + i, 3);
    expect_end(0, "plus");

`ifdef DRAW_SYMBOL_GEN_ERASE_EN
    start_draw(1, 3, 5, 5, 7, 1);
    for (int i = 0; i < 16; i++) expect_pix(1, "erase", i, 5 + i % 4, 5 + i / 4, 0);
    expect_end(1, "erase");
    start_draw(1, 3, 5, 5, 7, 0);
    for (int i = 0; i < 16; i++) expect_pix(1, "noerase", i, 5 + i % 4, 5 + i / 4, 7);
    expect_end(1, "noerase");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
